mem_arbiter: RTL and testbench

- Shares the single external SRAM between three requesters: the 6502 CPU, video fetch (VRAM character codes and VROM glyph rows) and the host/SPI bridge.
- CPU and video accesses start on the slot strobes produced by the timing block.
- Host accesses run only in a fixed free phase of the 16-cycle (1 µs) frame.
- Sits between timing/video/CPU glue and the SRAM pins; all access sequencing is owned here.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and grant encoding for the SRAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {IDLE, CPU, VRAM, VROM, HOST} owner_t;

    typedef logic [16:0] sram_addr_t;

    localparam int unsigned GRANT_W     = 3;
    localparam int unsigned GRANT_CPU   = 0;
    localparam int unsigned GRANT_VIDEO = 1;
    localparam int unsigned GRANT_HOST  = 2;

    // One-hot {host, video, cpu} grant for a given owner.
    function automatic logic [GRANT_W-1:0] grant_of(input owner_t owner);
        logic [GRANT_W-1:0] g;
        g = '0;
        case (owner)
            CPU:        g[GRANT_CPU]   = 1'b1;
            VRAM, VROM: g[GRANT_VIDEO] = 1'b1;
            HOST:       g[GRANT_HOST]  = 1'b1;
            default:    g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-SRAM arbiter for CPU, video fetch and host bridge with slot-based sequencing.
// Optional CPU-slot stealing for starved host requests: define MEM_ARB_CPU_STEAL_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter int unsigned FRAME_CYCLES  = 16,
    parameter int unsigned HOST_PHASE    = 12,
    parameter sram_addr_t  VRAM_BASE     = 17'h08000,
    parameter sram_addr_t  VROM_BASE     = 17'h1C000,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic               clk16_i,
    input  logic               reset_i,
    input  logic               cpu_en_i,
    input  logic               vram_en_i,
    input  logic               vrom_en_i,
    input  logic [15:0]        cpu_addr_i,
    input  logic               cpu_we_i,
    input  logic [7:0]         cpu_data_i,
    output logic [7:0]         cpu_data_o,
    output logic               cpu_done_o,
    output logic               cpu_rdy_o,
    input  logic [13:0]        video_addr_i,
    output logic [7:0]         video_data_o,
    output logic               vram_valid_o,
    output logic               vrom_valid_o,
    input  logic               host_req_i,
    input  logic               host_we_i,
    input  logic [16:0]        host_addr_i,
    input  logic [7:0]         host_data_i,
    output logic               host_ack_o,
    output logic [7:0]         host_data_o,
    output logic [16:0]        ram_addr_o,
    output logic [7:0]         ram_data_o,
    input  logic [7:0]         ram_data_i,
    output logic               ram_oe_o,
    output logic               ram_we_o,
    output logic [GRANT_W-1:0] grant_o
);

    localparam int unsigned PHASE_W = $clog2(FRAME_CYCLES);
    localparam int unsigned K_W     = $clog2(ACCESS_CYCLES);

    owner_t             state;
    owner_t             start_owner;
    sram_addr_t         start_addr;
    logic               start_wr;
    logic [7:0]         start_data;
    logic [PHASE_W-1:0] phase;
    logic [K_W-1:0]     k;
    logic               pending;
    logic               wr;
    logic               steal;

    logic unused_video_bits;
    assign unused_video_bits = ^video_addr_i[13:11];

`ifdef MEM_ARB_CPU_STEAL_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt;

    assign steal = cpu_en_i && pending && (starve_cnt >= STARVE_W'(STARVE_LIMIT));

    // Counts CPU strobes seen while the host waits; cleared when the host is served.
    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            starve_cnt <= '0;
        end else if (host_ack_o) begin
            starve_cnt <= '0;
        end else if (cpu_en_i && pending && !steal) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`else
    localparam int unsigned UNUSED_STARVE_LIMIT = STARVE_LIMIT;
    assign steal     = 1'b0;
    assign cpu_rdy_o = 1'b1;
`endif

    // Start decision in IDLE: vram > vrom > cpu (or stolen host) > host in its phase.
    always_comb begin
        start_owner = IDLE;
        start_addr  = '0;
        start_wr    = 1'b0;
        start_data  = '0;
        if (state == IDLE) begin
            if (vram_en_i) begin
                start_owner = VRAM;
                start_addr  = VRAM_BASE + sram_addr_t'(video_addr_i[9:0]);
            end else if (vrom_en_i) begin
                start_owner = VROM;
                start_addr  = VROM_BASE + sram_addr_t'(video_addr_i[10:0]);
            end else if (cpu_en_i && !steal) begin
                start_owner = CPU;
                start_addr  = {1'b0, cpu_addr_i};
                start_wr    = cpu_we_i;
                start_data  = cpu_we_i ? cpu_data_i : 8'h00;
            end else if (cpu_en_i || (pending && phase == PHASE_W'(HOST_PHASE))) begin
                start_owner = HOST;
                start_addr  = host_addr_i;
                start_wr    = host_we_i;
                start_data  = host_we_i ? host_data_i : 8'h00;
            end
        end
    end

    // Access sequencer, phase counter and host pending flag.
    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            state        <= IDLE;
            phase        <= '0;
            k            <= '0;
            pending      <= 1'b0;
            wr           <= 1'b0;
            cpu_data_o   <= '0;
            cpu_done_o   <= 1'b0;
            video_data_o <= '0;
            vram_valid_o <= 1'b0;
            vrom_valid_o <= 1'b0;
            host_ack_o   <= 1'b0;
            host_data_o  <= '0;
            ram_addr_o   <= '0;
            ram_data_o   <= '0;
            ram_oe_o     <= 1'b0;
            ram_we_o     <= 1'b0;
            grant_o      <= '0;
`ifdef MEM_ARB_CPU_STEAL_EN
            cpu_rdy_o    <= 1'b1;
`endif
        end else begin
            cpu_done_o   <= 1'b0;
            vram_valid_o <= 1'b0;
            vrom_valid_o <= 1'b0;
            host_ack_o   <= 1'b0;

            // The CPU strobe cycle is phase 0 of the frame.
            if (cpu_en_i) begin
                phase <= PHASE_W'(1);
            end else if (phase == PHASE_W'(FRAME_CYCLES - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + PHASE_W'(1);
            end

            // Pending ignores the request level during the ack cycle itself.
            if (host_ack_o) begin
                pending <= 1'b0;
            end else if (host_req_i) begin
                pending <= 1'b1;
            end

            if (state == IDLE) begin
                k <= '0;
                if (start_owner != IDLE) begin
                    state      <= start_owner;
                    ram_addr_o <= start_addr;
                    ram_data_o <= start_data;
                    wr         <= start_wr;
                    ram_oe_o   <= !start_wr;
                    grant_o    <= grant_of(start_owner);
`ifdef MEM_ARB_CPU_STEAL_EN
                    cpu_rdy_o  <= !(start_owner == HOST && cpu_en_i);
`endif
                end
            end else if (k == K_W'(ACCESS_CYCLES - 1)) begin
                state    <= IDLE;
                k        <= '0;
                ram_oe_o <= 1'b0;
                ram_we_o <= 1'b0;
                grant_o  <= '0;
`ifdef MEM_ARB_CPU_STEAL_EN
                cpu_rdy_o <= 1'b1;
`endif
                case (state)
                    CPU: begin
                        cpu_done_o <= 1'b1;
                        if (!wr) cpu_data_o <= ram_data_i;
                    end
                    VRAM: begin
                        vram_valid_o <= 1'b1;
                        video_data_o <= ram_data_i;
                    end
                    VROM: begin
                        vrom_valid_o <= 1'b1;
                        video_data_o <= ram_data_i;
                    end
                    HOST: begin
                        host_ack_o <= 1'b1;
                        if (!wr) host_data_o <= ram_data_i;
                    end
                    default: ;
                endcase
            end else begin
                k <= k + K_W'(1);
                // Write strobe covers k = 1 .. ACCESS_CYCLES-2.
                ram_we_o <= wr && (k != K_W'(ACCESS_CYCLES - 2));
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural SRAM.
module tb_mem_arbiter;

    logic        clk16_i = 1'b0;
    logic        reset_i;
    logic        cpu_en_i, vram_en_i, vrom_en_i;
    logic [15:0] cpu_addr_i;
    logic        cpu_we_i;
    logic [7:0]  cpu_data_i;
    logic [7:0]  cpu_data_o;
    logic        cpu_done_o, cpu_rdy_o;
    logic [13:0] video_addr_i;
    logic [7:0]  video_data_o;
    logic        vram_valid_o, vrom_valid_o;
    logic        host_req_i, host_we_i;
    logic [16:0] host_addr_i;
    logic [7:0]  host_data_i;
    logic        host_ack_o;
    logic [7:0]  host_data_o;
    logic [16:0] ram_addr_o;
    logic [7:0]  ram_data_o, ram_data_i;
    logic        ram_oe_o, ram_we_o;
    logic [2:0]  grant_o;

    mem_arbiter dut (
        .clk16_i(clk16_i), .reset_i(reset_i),
        .cpu_en_i(cpu_en_i), .vram_en_i(vram_en_i), .vrom_en_i(vrom_en_i),
        .cpu_addr_i(cpu_addr_i), .cpu_we_i(cpu_we_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_done_o(cpu_done_o), .cpu_rdy_o(cpu_rdy_o),
        .video_addr_i(video_addr_i), .video_data_o(video_data_o),
        .vram_valid_o(vram_valid_o), .vrom_valid_o(vrom_valid_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_data_i(host_data_i), .host_ack_o(host_ack_o), .host_data_o(host_data_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
        .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o), .grant_o(grant_o)
    );

    always #5 clk16_i = ~clk16_i;

    // SRAM model: preloaded while reset is high, written on we.
    logic [7:0] mem [0:131071];
    assign ram_data_i = ram_oe_o ? mem[ram_addr_o] : 8'h00;
    always @(posedge clk16_i) begin
        if (reset_i) begin
            mem[17'h08005] <= 8'h41;
            mem[17'h01234] <= 8'h3C;
            mem[17'h1C010] <= 8'h5A;
        end else if (ram_we_o) begin
            mem[ram_addr_o] <= ram_data_o;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          n_oe, n_we, n_cpu, n_vram, n_vrom, n_ack, t_done, we_mask, rdy_low_total;
    logic [16:0] addr0;
    logic [2:0]  grant0;

    // Observe n cycles after a strobe; optionally inject a cpu strobe at cycle cpu_at.
    task automatic watch(input int n, input int cpu_at);
        n_oe = 0; n_we = 0; n_cpu = 0; n_vram = 0; n_vrom = 0; n_ack = 0;
        t_done = 0; we_mask = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk16_i);
            if (i == 1) begin
                addr0  = ram_addr_o;
                grant0 = grant_o;
            end
            if (ram_oe_o) n_oe++;
            if (ram_we_o) begin
                n_we++;
                we_mask = we_mask | (1 << i);
            end
            if (cpu_done_o) n_cpu++;
            if (vram_valid_o) n_vram++;
            if (vrom_valid_o) n_vrom++;
            if (host_ack_o) n_ack++;
            if (!cpu_rdy_o) rdy_low_total++;
            if ((cpu_done_o || vram_valid_o || vrom_valid_o || host_ack_o) && t_done == 0) t_done = i;
            cpu_en_i = 1'b0; vram_en_i = 1'b0; vrom_en_i = 1'b0;
            if (i == cpu_at) cpu_en_i = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        int first_h, ack1, ack2, found;
        logic [16:0] addr13;
        rdy_low_total = 0;
        reset_i = 1'b1;
        cpu_en_i = 0; vram_en_i = 0; vrom_en_i = 0;
        cpu_addr_i = '0; cpu_we_i = 0; cpu_data_i = '0;
        video_addr_i = '0;
        host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_data_i = '0;
        repeat (3) @(negedge clk16_i);

        // Reset values
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_ram_ctl", 32'({ram_oe_o, ram_we_o, ram_addr_o, ram_data_o}), 32'h0);
        check("rst_pulses", 32'({cpu_done_o, vram_valid_o, vrom_valid_o, host_ack_o}), 32'h0);
        check("rst_rdy", 32'(cpu_rdy_o), 32'h1);
        reset_i = 1'b0;

        // VRAM read
        video_addr_i = 14'h0005; vram_en_i = 1'b1;
        watch(7, 0);
        check("vram_addr", 32'(addr0), 32'h08005);
        check("vram_grant", 32'(grant0), 32'h2);
        check("vram_oe_cycles", n_oe, 4);
        check("vram_valid_cnt", n_vram, 1);
        check("vram_latency", t_done, 5);
        check("vram_data", 32'(video_data_o), 32'h41);

        // CPU write
        cpu_addr_i = 16'h8000; cpu_data_i = 8'hA5; cpu_we_i = 1'b1; cpu_en_i = 1'b1;
        watch(7, 0);
        cpu_we_i = 1'b0;
        check("cpuw_grant", 32'(grant0), 32'h1);
        check("cpuw_we_mask", we_mask, 32'hC);
        check("cpuw_oe_cycles", n_oe, 0);
        check("cpuw_done_cnt", n_cpu, 1);
        check("cpuw_mem", 32'(mem[17'h08000]), 32'hA5);

        // CPU read
        cpu_addr_i = 16'h1234; cpu_en_i = 1'b1;
        watch(7, 0);
        check("cpur_data", 32'(cpu_data_o), 32'h3C);
        check("cpur_latency", t_done, 5);

        // Host read: raised at phase 3, starts at phase 12, re-requested after ack
        host_addr_i = 17'h1C010; host_we_i = 1'b0;
        first_h = 0; ack1 = 0; ack2 = 0; n_ack = 0; addr13 = '0;
        cpu_en_i = 1'b1;
        for (int j = 1; j <= 36; j++) begin
            @(negedge clk16_i);
            if (grant_o[2] && first_h == 0) first_h = j;
            if (j == 13) addr13 = ram_addr_o;
            if (host_ack_o) begin
                n_ack++;
                if (ack1 == 0) ack1 = j; else ack2 = j;
            end
            cpu_en_i   = 1'b0;
            host_req_i = (j >= 3 && j < 19);
        end
        check("host_first_grant", first_h, 13);
        check("host_addr", 32'(addr13), 32'h1C010);
        check("host_ack1", ack1, 17);
        check("host_ack2", ack2, 33);
        check("host_ack_cnt", n_ack, 2);
        check("host_data", 32'(host_data_o), 32'h5A);

        // Simultaneous vram and cpu strobes
        video_addr_i = 14'h0005; vram_en_i = 1'b1; cpu_en_i = 1'b1;
        watch(7, 0);
        check("collide_vram", n_vram, 1);
        check("collide_cpu", n_cpu, 0);

        // CPU strobe during VROM access is dropped
        video_addr_i = 14'h3810; vrom_en_i = 1'b1;
        watch(9, 2);
        check("vrom_addr", 32'(addr0), 32'h1C010);
        check("vrom_valid_cnt", n_vrom, 1);
        check("vrom_cpu_drop", n_cpu, 0);
        check("vrom_data", 32'(video_data_o), 32'h5A);

        // Reset at k = 2 of a host write
        host_addr_i = 17'h00100; host_data_i = 8'h77; host_we_i = 1'b1; host_req_i = 1'b1;
        found = 0;
        for (int j = 0; j < 40 && found == 0; j++) begin
            @(negedge clk16_i);
            if (grant_o[2]) found = 1;
        end
        check("hostw_started", found, 1);
        @(negedge clk16_i);
        check("hostw_we_k1", 32'(ram_we_o), 32'h1);
        @(negedge clk16_i);
        reset_i = 1'b1; host_req_i = 1'b0;
        @(negedge clk16_i);
        check("abort_ram_ctl", 32'({ram_oe_o, ram_we_o, ram_addr_o, ram_data_o}), 32'h0);
        check("abort_grant_ack", 32'({grant_o, host_ack_o}), 32'h0);
        check("abort_data", 32'({cpu_data_o, video_data_o, host_data_o}), 32'h0);
        check("abort_rdy", 32'(cpu_rdy_o), 32'h1);
        reset_i = 1'b0; host_we_i = 1'b0;
        watch(20, 0);
        check("abort_no_ack", n_ack, 0);

`ifdef MEM_ARB_CPU_STEAL_EN
        begin
            int s_cpu, s_ack, s_rdy;
            s_cpu = 0; s_ack = 0; s_rdy = 0;
            host_addr_i = 17'h1C010; host_we_i = 1'b0; video_addr_i = 14'h0005;
            cpu_en_i = 1'b1;
            @(negedge clk16_i);
            cpu_en_i = 1'b0;
            repeat (5) @(negedge clk16_i);
            host_req_i = 1'b1;
            @(negedge clk16_i);
            for (int f = 0; f < 6; f++) begin
                for (int j = 0; j < 16; j++) begin
                    cpu_en_i  = (f < 5) && (j == 0);
                    vram_en_i = (f < 5) && (j == 12);
                    @(negedge clk16_i);
                    if (cpu_done_o) s_cpu++;
                    if (host_ack_o) begin
                        s_ack++;
                        host_req_i = 1'b0;
                    end
                    if (!cpu_rdy_o) s_rdy++;
                end
            end
            check("steal_cpu_served", s_cpu, 4);
            check("steal_ack_cnt", s_ack, 1);
            check("steal_rdy_low", s_rdy, 4);
            check("steal_host_data", 32'(host_data_o), 32'h5A);
        end
`else
        check("rdy_never_low", rdy_low_total, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
